// File: rtl/sensor_defs.sv
// Shared sensor definitions: event codes, presence-filter FSM states and counter sizing helper.
package sensor_defs;

   localparam int unsigned MS_PER_SEC = 1000;

   localparam logic [1:0] EVT_NONE = 2'b00;
   localparam logic [1:0] EVT_PET  = 2'b01;
   localparam logic [1:0] EVT_HOLD = 2'b10;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StArm      = 3'd1,
      StPresent  = 3'd2,
      StRelease  = 3'd3,
      StCooldown = 3'd4
   } filt_state_e;

   // Width of a counter that must hold 0..max_val inclusive (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler: one-cycle tick every CLK_FREQ/1000 clocks.
module ms_tick_gen
   import sensor_defs::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned Period = CLK_FREQ / MS_PER_SEC;
   localparam int unsigned CntW   = cnt_width(Period - 1);

   logic [CntW-1:0] cnt_q;

   assign tick = (cnt_q == CntW'(Period - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/presence_event_filter.sv
// Debounces the ultrasound presence level, times each visit and posts PET/HOLD events
// over a valid/ack handshake.
module presence_event_filter
   import sensor_defs::*;
#(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned PET_MAX_MS  = 1000,
   parameter int unsigned HOLD_MS     = 3000,
   parameter int unsigned COOLDOWN_MS = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       object_detected,
   input  logic       evt_ack,
   output logic       present,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   output logic       evt_overrun
);

   localparam int unsigned DebW = cnt_width(DEBOUNCE_MS);
   localparam int unsigned DurW = cnt_width(HOLD_MS);
   localparam int unsigned CdW  = cnt_width(COOLDOWN_MS);

   logic            ms_tick;
   logic            sync_q, det_s_q;
   filt_state_e     state_q, state_d;
   logic [DebW-1:0] deb_q, deb_d;
   logic [DurW-1:0] dur_q, dur_d;
   logic [CdW-1:0]  cd_q, cd_d;
   logic            hold_done_q, hold_done_d;
   logic            present_q, present_d;
   logic            evt_valid_q, evt_valid_d;
   logic [1:0]      evt_code_q, evt_code_d;
   logic            overrun_q, overrun_d;
   logic            post;
   logic [1:0]      post_code;
   logic            deb_done, dur_sat;

   ms_tick_gen #(
      .CLK_FREQ(CLK_FREQ)
   ) u_ms_tick (
      .clk (clk),
      .rst (rst),
      .tick(ms_tick)
   );

   assign deb_done = (deb_q == DebW'(DEBOUNCE_MS));
   assign dur_sat  = (dur_q == DurW'(HOLD_MS));

   always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      dur_d       = dur_q;
      cd_d        = cd_q;
      hold_done_d = hold_done_q;
      present_d   = present_q;
      post        = 1'b0;
      post_code   = EVT_NONE;

      unique case (state_q)
         StIdle: begin
            if (det_s_q) begin
               state_d = StArm;
               deb_d   = '0;
            end
         end
         StArm: begin
            if (!det_s_q) begin
               state_d = StIdle;
            end else if (deb_done) begin
               state_d     = StPresent;
               present_d   = 1'b1;
               dur_d       = '0;
               hold_done_d = 1'b0;
            end else if (ms_tick) begin
               deb_d = deb_q + DebW'(1);
            end
         end
         StPresent: begin
            if (ms_tick && !dur_sat) dur_d = dur_q + DurW'(1);
            if (dur_sat && !hold_done_q) begin
               post        = 1'b1;
               post_code   = EVT_HOLD;
               hold_done_d = 1'b1;
            end
            if (!det_s_q) begin
               state_d = StRelease;
               deb_d   = '0;
            end
         end
         StRelease: begin
            // Visit time keeps running here so a short dropout does not restart the visit.
            if (ms_tick && !dur_sat) dur_d = dur_q + DurW'(1);
            if (det_s_q) begin
               state_d = StPresent;
            end else if (deb_done) begin
               state_d   = StCooldown;
               present_d = 1'b0;
               cd_d      = '0;
               if ((32'(dur_q) < PET_MAX_MS) && !hold_done_q) begin
                  post      = 1'b1;
                  post_code = EVT_PET;
               end
            end else if (ms_tick) begin
               deb_d = deb_q + DebW'(1);
            end
         end
         StCooldown: begin
            if (cd_q == CdW'(COOLDOWN_MS)) begin
               state_d = StIdle;
            end else if (ms_tick) begin
               cd_d = cd_q + CdW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Event register: a post while an unacked event is pending is dropped and flagged.
   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_code_d  = evt_code_q;
      overrun_d   = 1'b0;
      if (post) begin
         if (evt_valid_q && !evt_ack) begin
            overrun_d = 1'b1;
         end else begin
            evt_valid_d = 1'b1;
            evt_code_d  = post_code;
         end
      end else if (evt_valid_q && evt_ack) begin
         evt_valid_d = 1'b0;
         evt_code_d  = EVT_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= 1'b0;
         det_s_q     <= 1'b0;
         state_q     <= StIdle;
         deb_q       <= '0;
         dur_q       <= '0;
         cd_q        <= '0;
         hold_done_q <= 1'b0;
         present_q   <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_code_q  <= EVT_NONE;
         overrun_q   <= 1'b0;
      end else begin
         sync_q      <= object_detected;
         det_s_q     <= sync_q;
         state_q     <= state_d;
         deb_q       <= deb_d;
         dur_q       <= dur_d;
         cd_q        <= cd_d;
         hold_done_q <= hold_done_d;
         present_q   <= present_d;
         evt_valid_q <= evt_valid_d;
         evt_code_q  <= evt_code_d;
         overrun_q   <= overrun_d;
      end
   end

   assign present     = present_q;
   assign evt_valid   = evt_valid_q;
   assign evt_code    = evt_code_q;
   assign evt_overrun = overrun_q;

endmodule
